// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the architectural register file and its neighbours
// (RoB, LSB, RS): register count, RoB-id width, the "no pending producer"
// tag value and the common typedefs.
// ----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int REG_NUM = 32;   // architectural register count
    localparam int TAG_W   = 5;    // RoB id width (id = RoB slot + 1)
    localparam int DATA_W  = 32;   // register value width
    localparam int IDX_W   = $clog2(REG_NUM);

    // RoB id shared with the RoB, LSB and RS; 0 means "value is valid".
    typedef logic [TAG_W-1:0]  rob_id_t;
    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam rob_id_t NO_TAG = '0;

    // Whole-file state, packed so it can be passed to the read ports as-is.
    typedef word_t   [REG_NUM-1:0] value_array_t;
    typedef rob_id_t [REG_NUM-1:0] tag_array_t;

    // Commit bus as seen by the register file.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        rob_id_t  q;
        word_t    v;
    } commit_bus_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// ----------------------------------------------------------------------------
// reg_file_read_port
// One combinational operand lookup into the register file.
//
// Ports:
//   rs_i     : source register index
//   value_i  : current register values (all entries)
//   tag_i    : current producer tags (all entries)
//   commit_i : same-cycle commit bus, used for bypass
//   v_o      : operand value (meaningful when q_o == NO_TAG)
//   q_o      : operand producer tag
//
// Index 0 always reads as 0/NO_TAG. A commit whose id still matches the
// register's pending tag is forwarded directly, so the dispatcher never
// waits one extra cycle for a value that is being retired right now.
// ----------------------------------------------------------------------------
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  logic [IDX_W-1:0]          rs_i,
    input  value_array_t              value_i,
    input  tag_array_t                tag_i,
    input  commit_bus_t               commit_i,
    output logic [DATA_W-1:0]         v_o,
    output logic [TAG_W-1:0]          q_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the if/else leaves it unassigned (no latch).
        v_o = '0;
        q_o = NO_TAG;
        if (rs_i == '0) begin
            v_o = '0;
            q_o = NO_TAG;
        end else if (commit_i.valid && commit_i.rd == rs_i &&
                     tag_i[rs_i] == commit_i.q) begin
            // Producer is retiring this cycle: forward its value as ready.
            v_o = commit_i.v;
            q_o = NO_TAG;
        end else begin
            v_o = value_i[rs_i];
            q_o = tag_i[rs_i];
        end
    end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// Architectural register file with rename tags. Sits between the reorder
// buffer's commit port and the dispatcher's operand lookup. Holds 32 x 32-bit
// values plus a producer tag (RoB id, 0 = no pending producer) per register.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global stall, low freezes)
//   rs1/rs2_from_dispatcher       : operand indices
//   V1/Q1, V2/Q2_to_dispatcher    : operand value / producer tag
//   en_signal/rd/Q_from_dispatcher: rename rd to RoB id Q
//   commit_flag, rd/Q/V_from_rob  : commit write-back
//   rollback_flag                 : drop all pending tags
//
// Tag priority per register: reset > rollback > rename > commit-clear.
// A commit always writes its value; it only clears the tag if that tag still
// names the committing RoB entry and nobody renames the register this cycle.
//
// Optional build macro REG_FILE_TRACE_EN: adds a free-running cycle counter
// and prints every effective commit (cycle, rd, Q, V). No functional change.
// ----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,

    input  logic [IDX_W-1:0]   rs1_from_dispatcher,
    input  logic [IDX_W-1:0]   rs2_from_dispatcher,
    output logic [DATA_W-1:0]  V1_to_dispatcher,
    output logic [TAG_W-1:0]   Q1_to_dispatcher,
    output logic [DATA_W-1:0]  V2_to_dispatcher,
    output logic [TAG_W-1:0]   Q2_to_dispatcher,

    input  logic               en_signal_from_dispatcher,
    input  logic [IDX_W-1:0]   rd_from_dispatcher,
    input  logic [TAG_W-1:0]   Q_from_dispatcher,

    input  logic               commit_flag,
    input  logic [IDX_W-1:0]   rd_from_rob,
    input  logic [TAG_W-1:0]   Q_from_rob,
    input  logic [DATA_W-1:0]  V_from_rob,

    input  logic               rollback_flag
);

    value_array_t value_q, value_d;
    tag_array_t   tag_q,   tag_d;

    commit_bus_t  commit_bus;
    logic         rename_req;
    logic         commit_req;

    assign commit_bus = '{valid: commit_flag,
                          rd:    rd_from_rob,
                          q:     Q_from_rob,
                          v:     V_from_rob};

    // Register 0 is hard-wired: requests aimed at it are simply never raised.
    assign rename_req = en_signal_from_dispatcher && (rd_from_dispatcher != '0);
    assign commit_req = commit_flag && (rd_from_rob != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later statements see
        // earlier ones (rollback/rename override commit-clear by order).
        value_d = value_q;
        tag_d   = tag_q;

        if (commit_req) begin
            value_d[rd_from_rob] = V_from_rob;
            if (tag_q[rd_from_rob] == Q_from_rob &&
                !(rename_req && rd_from_dispatcher == rd_from_rob)) begin
                tag_d[rd_from_rob] = NO_TAG;
            end
        end

        if (rollback_flag) begin
            // Values survive a flush; only the speculative mapping is dropped,
            // including any rename arriving in the same cycle.
            for (int i = 0; i < REG_NUM; i++) begin
                tag_d[i] = NO_TAG;
            end
        end else if (rename_req) begin
            tag_d[rd_from_dispatcher] = Q_from_dispatcher;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: this storage is architecturally required to read 0 after
            // reset, so it is built from resettable flops rather than a RAM.
            value_q <= '0;
            tag_q   <= '0;
        end else if (rdy_in) begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand read ports (combinational, with commit bypass)
    // ------------------------------------------------------------------
    reg_file_read_port u_read_rs1 (
        .rs_i     (rs1_from_dispatcher),
        .value_i  (value_q),
        .tag_i    (tag_q),
        .commit_i (commit_bus),
        .v_o      (V1_to_dispatcher),
        .q_o      (Q1_to_dispatcher)
    );

    reg_file_read_port u_read_rs2 (
        .rs_i     (rs2_from_dispatcher),
        .value_i  (value_q),
        .tag_i    (tag_q),
        .commit_i (commit_bus),
        .v_o      (V2_to_dispatcher),
        .q_o      (Q2_to_dispatcher)
    );

`ifdef REG_FILE_TRACE_EN
    // ------------------------------------------------------------------
    // Commit trace
    // ------------------------------------------------------------------
    logic [31:0] cycle_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (rdy_in && commit_req) begin
                $display("[reg_file] cycle=%0d commit rd=%0d Q=%0d V=%h",
                         cycle_q, rd_from_rob, Q_from_rob, V_from_rob);
            end
        end
    end
`endif

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
// Directed bench for reg_file: reset, rename/commit with bypass, stale
// commit, same-cycle rename+commit, rollback, register 0 and stall.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  rs1_from_dispatcher;
    logic [4:0]  rs2_from_dispatcher;
    logic [31:0] V1_to_dispatcher;
    logic [4:0]  Q1_to_dispatcher;
    logic [31:0] V2_to_dispatcher;
    logic [4:0]  Q2_to_dispatcher;
    logic        en_signal_from_dispatcher;
    logic [4:0]  rd_from_dispatcher;
    logic [4:0]  Q_from_dispatcher;
    logic        commit_flag;
    logic [4:0]  rd_from_rob;
    logic [4:0]  Q_from_rob;
    logic [31:0] V_from_rob;
    logic        rollback_flag;

    int total = 0;
    int bad   = 0;

    reg_file dut (
        .clk_in                    (clk_in),
        .rst_in                    (rst_in),
        .rdy_in                    (rdy_in),
        .rs1_from_dispatcher       (rs1_from_dispatcher),
        .rs2_from_dispatcher       (rs2_from_dispatcher),
        .V1_to_dispatcher          (V1_to_dispatcher),
        .Q1_to_dispatcher          (Q1_to_dispatcher),
        .V2_to_dispatcher          (V2_to_dispatcher),
        .Q2_to_dispatcher          (Q2_to_dispatcher),
        .en_signal_from_dispatcher (en_signal_from_dispatcher),
        .rd_from_dispatcher        (rd_from_dispatcher),
        .Q_from_dispatcher         (Q_from_dispatcher),
        .commit_flag               (commit_flag),
        .rd_from_rob               (rd_from_rob),
        .Q_from_rob                (Q_from_rob),
        .V_from_rob                (V_from_rob),
        .rollback_flag             (rollback_flag)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change 1 ns after the rising edge; outputs are sampled a
    // further 1 ns later, well away from the next edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        en_signal_from_dispatcher = 1'b0;
        rd_from_dispatcher        = '0;
        Q_from_dispatcher         = '0;
        commit_flag               = 1'b0;
        rd_from_rob               = '0;
        Q_from_rob                = '0;
        V_from_rob                = '0;
        rollback_flag             = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] q);
        en_signal_from_dispatcher = 1'b1;
        rd_from_dispatcher        = rd;
        Q_from_dispatcher         = q;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] q,
                          input logic [31:0] v);
        commit_flag = 1'b1;
        rd_from_rob = rd;
        Q_from_rob  = q;
        V_from_rob  = v;
    endtask

    task automatic read(input logic [4:0] a, input logic [4:0] b);
        rs1_from_dispatcher = a;
        rs2_from_dispatcher = b;
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        read(5'd5, 5'd0);
        total++; if (V1_to_dispatcher !== 32'h0) begin bad++;
            $display("FAIL reset_v1: got %h expected %h", V1_to_dispatcher, 32'h0); end
        total++; if (Q1_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL reset_q1: got %0d expected %0d", Q1_to_dispatcher, 0); end
        total++; if (V2_to_dispatcher !== 32'h0) begin bad++;
            $display("FAIL reset_v2: got %h expected %h", V2_to_dispatcher, 32'h0); end
        total++; if (Q2_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL reset_q2: got %0d expected %0d", Q2_to_dispatcher, 0); end
        read(5'd31, 5'd17);
        total++; if ({V1_to_dispatcher, Q1_to_dispatcher, V2_to_dispatcher, Q2_to_dispatcher} !== 74'h0) begin bad++;
            $display("FAIL reset_x31_x17: got %h/%0d %h/%0d expected all 0",
                     V1_to_dispatcher, Q1_to_dispatcher, V2_to_dispatcher, Q2_to_dispatcher); end
    endtask

    task automatic test_rename_commit();
        rename(5'd5, 5'd3);
        tick();
        idle_inputs();
        read(5'd5, 5'd0);
        total++; if (Q1_to_dispatcher !== 5'd3) begin bad++;
            $display("FAIL rename_q1: got %0d expected %0d", Q1_to_dispatcher, 3); end
        commit(5'd5, 5'd3, 32'h1234);
        read(5'd5, 5'd0);
        total++; if (V1_to_dispatcher !== 32'h1234) begin bad++;
            $display("FAIL bypass_v1: got %h expected %h", V1_to_dispatcher, 32'h1234); end
        total++; if (Q1_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL bypass_q1: got %0d expected %0d", Q1_to_dispatcher, 0); end
        tick();
        idle_inputs();
        read(5'd5, 5'd0);
        total++; if (V1_to_dispatcher !== 32'h1234) begin bad++;
            $display("FAIL commit_v1: got %h expected %h", V1_to_dispatcher, 32'h1234); end
        total++; if (Q1_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL commit_q1: got %0d expected %0d", Q1_to_dispatcher, 0); end
    endtask

    task automatic test_stale_commit();
        rename(5'd7, 5'd2);
        tick();
        rename(5'd7, 5'd6);
        tick();
        idle_inputs();
        commit(5'd7, 5'd2, 32'hAA);
        read(5'd7, 5'd0);
        // Tag 6 does not match the committing id 2: no bypass.
        total++; if (V1_to_dispatcher !== 32'h0 || Q1_to_dispatcher !== 5'd6) begin bad++;
            $display("FAIL stale_no_bypass: got %h/%0d expected %h/%0d",
                     V1_to_dispatcher, Q1_to_dispatcher, 32'h0, 6); end
        tick();
        idle_inputs();
        read(5'd7, 5'd0);
        total++; if (V1_to_dispatcher !== 32'hAA) begin bad++;
            $display("FAIL stale_value: got %h expected %h", V1_to_dispatcher, 32'hAA); end
        total++; if (Q1_to_dispatcher !== 5'd6) begin bad++;
            $display("FAIL stale_tag: got %0d expected %0d", Q1_to_dispatcher, 6); end
    endtask

    task automatic test_back_to_back();
        rename(5'd9, 5'd1);
        tick();
        idle_inputs();
        rename(5'd9, 5'd4);
        commit(5'd9, 5'd1, 32'h55);
        read(5'd0, 5'd9);
        // Same-cycle rename is invisible; commit matches old tag 1: bypass.
        total++; if (V2_to_dispatcher !== 32'h55 || Q2_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL b2b_bypass: got %h/%0d expected %h/%0d",
                     V2_to_dispatcher, Q2_to_dispatcher, 32'h55, 0); end
        tick();
        idle_inputs();
        read(5'd0, 5'd9);
        total++; if (V2_to_dispatcher !== 32'h55) begin bad++;
            $display("FAIL b2b_value: got %h expected %h", V2_to_dispatcher, 32'h55); end
        total++; if (Q2_to_dispatcher !== 5'd4) begin bad++;
            $display("FAIL b2b_tag: got %0d expected %0d", Q2_to_dispatcher, 4); end
    endtask

    task automatic test_rollback();
        rename(5'd1, 5'd2);
        tick();
        rename(5'd2, 5'd3);
        tick();
        idle_inputs();
        read(5'd1, 5'd2);
        total++; if (Q1_to_dispatcher !== 5'd2 || Q2_to_dispatcher !== 5'd3) begin bad++;
            $display("FAIL pre_rollback_tags: got %0d/%0d expected 2/3",
                     Q1_to_dispatcher, Q2_to_dispatcher); end
        rollback_flag = 1'b1;
        rename(5'd3, 5'd5);
        tick();
        idle_inputs();
        read(5'd1, 5'd2);
        total++; if (Q1_to_dispatcher !== 5'd0 || Q2_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL rollback_tags: got %0d/%0d expected 0/0",
                     Q1_to_dispatcher, Q2_to_dispatcher); end
        read(5'd3, 5'd9);
        total++; if (Q1_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL rollback_drop_rename: got %0d expected %0d", Q1_to_dispatcher, 0); end
        total++; if (V2_to_dispatcher !== 32'h55 || Q2_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL rollback_x9: got %h/%0d expected %h/%0d",
                     V2_to_dispatcher, Q2_to_dispatcher, 32'h55, 0); end
        read(5'd5, 5'd7);
        total++; if (V1_to_dispatcher !== 32'h1234 || V2_to_dispatcher !== 32'hAA ||
                     Q2_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL rollback_values: got %h %h/%0d expected %h %h/%0d",
                     V1_to_dispatcher, V2_to_dispatcher, Q2_to_dispatcher, 32'h1234, 32'hAA, 0); end
    endtask

    task automatic test_reg_zero();
        rename(5'd0, 5'd8);
        commit(5'd0, 5'd8, 32'hFF);
        read(5'd0, 5'd0);
        total++; if (V1_to_dispatcher !== 32'h0 || Q1_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL x0_during: got %h/%0d expected 0/0", V1_to_dispatcher, Q1_to_dispatcher); end
        tick();
        idle_inputs();
        read(5'd0, 5'd0);
        total++; if (V1_to_dispatcher !== 32'h0 || Q1_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL x0_after: got %h/%0d expected 0/0", V1_to_dispatcher, Q1_to_dispatcher); end
    endtask

    task automatic test_stall();
        rename(5'd6, 5'd7);
        tick();
        idle_inputs();
        rdy_in        = 1'b0;
        commit(5'd4, 5'd1, 32'h77);
        rename(5'd4, 5'd6);
        rollback_flag = 1'b1;
        tick();
        tick();
        idle_inputs();
        rdy_in = 1'b1;
        read(5'd4, 5'd6);
        total++; if (V1_to_dispatcher !== 32'h0 || Q1_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL stall_x4: got %h/%0d expected 0/0", V1_to_dispatcher, Q1_to_dispatcher); end
        total++; if (Q2_to_dispatcher !== 5'd7) begin bad++;
            $display("FAIL stall_rollback_ignored: got %0d expected %0d", Q2_to_dispatcher, 7); end
        // Bypass still works while stalled.
        rdy_in = 1'b0;
        commit(5'd6, 5'd7, 32'hBEEF);
        read(5'd6, 5'd0);
        total++; if (V1_to_dispatcher !== 32'hBEEF || Q1_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL stall_bypass: got %h/%0d expected %h/%0d",
                     V1_to_dispatcher, Q1_to_dispatcher, 32'hBEEF, 0); end
        tick();
        idle_inputs();
        rdy_in = 1'b1;
        read(5'd6, 5'd0);
        total++; if (V1_to_dispatcher !== 32'h0 || Q1_to_dispatcher !== 5'd7) begin bad++;
            $display("FAIL stall_no_commit: got %h/%0d expected %h/%0d",
                     V1_to_dispatcher, Q1_to_dispatcher, 32'h0, 7); end
    endtask

    task automatic test_reset_override();
        rst_in = 1'b1;
        rename(5'd10, 5'd9);
        commit(5'd5, 5'd1, 32'hDEAD);
        tick();
        rst_in = 1'b0;
        idle_inputs();
        read(5'd5, 5'd10);
        total++; if (V1_to_dispatcher !== 32'h0 || Q2_to_dispatcher !== 5'd0) begin bad++;
            $display("FAIL reset_override: got %h/%0d expected 0/0",
                     V1_to_dispatcher, Q2_to_dispatcher); end
        read(5'd6, 5'd9);
        total++; if (Q1_to_dispatcher !== 5'd0 || V2_to_dispatcher !== 32'h0) begin bad++;
            $display("FAIL reset_clears_state: got %0d/%h expected 0/0",
                     Q1_to_dispatcher, V2_to_dispatcher); end
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        rs1_from_dispatcher = '0;
        rs2_from_dispatcher = '0;
        idle_inputs();
        tick();
        tick();
        rst_in = 1'b0;

        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_back_to_back();
        test_rollback();
        test_reg_zero();
        test_stall();
        test_reset_override();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags, sitting directly downstream of the reorder buffer's commit port and upstream of the dispatcher's operand lookup. It holds 32 × 32-bit values plus a 5-bit producer tag (RoB id, 1-based; 0 = no pending producer) per register. Dispatch renames a destination to its RoB id. Commit writes back the value and clears the tag when it still matches. Rollback discards all pending tags.

## Interface
- `REG_NUM`, 32: architectural register count.
- `TAG_W`, 5: RoB id width; id = RoB slot + 1; 0 means "value valid".
- `clk_in` input 1: single clock, rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `rdy_in` input 1: global stall; low freezes all state.
- `rs1_from_dispatcher` input 5: source register 1 index.
- `rs2_from_dispatcher` input 5: source register 2 index.
- `V1_to_dispatcher` output 32: rs1 value (meaningful when Q1 = 0).
- `Q1_to_dispatcher` output 5: rs1 producer tag.
- `V2_to_dispatcher` output 32: rs2 value.
- `Q2_to_dispatcher` output 5: rs2 producer tag.
- `en_signal_from_dispatcher` input 1: rename request this cycle.
- `rd_from_dispatcher` input 5: destination to rename.
- `Q_from_dispatcher` input 5: RoB id allocated to that destination.
- `commit_flag` input 1: RoB commit valid.
- `rd_from_rob` input 5: committed destination.
- `Q_from_rob` input 5: committed RoB id.
- `V_from_rob` input 32: committed value.
- `rollback_flag` input 1: flush all speculative state.

## Operation
- State: `value[0..31]`, `tag[0..31]`.
- Reads are combinational from the current state plus same-cycle commit bypass:
  - If `rs == 0`, return V = 0, Q = 0.
  - If `commit_flag && rd_from_rob == rs && tag[rs] == Q_from_rob`, return V = `V_from_rob`, Q = 0.
  - Otherwise return `value[rs]`, `tag[rs]`.
- A same-cycle rename is never visible to reads. An instruction whose rs equals its own rd sees the old mapping.
- Commit, when `commit_flag` is high and `rd_from_rob != 0`:
  - `value[rd] <= V_from_rob` unconditionally.
  - `tag[rd] <= 0` only if `tag[rd] == Q_from_rob` and no same-cycle rename targets the same rd.
- Rename, when `en_signal_from_dispatcher` is high, `rd_from_dispatcher != 0`, and no rollback: `tag[rd] <= Q_from_dispatcher`.
- Rename and commit to the same rd in the same cycle: value is written and tag becomes the new Q. Rename wins the tag.
- Rollback: every `tag <= 0`. Values are retained. A same-cycle commit still writes its value. A same-cycle rename is dropped.
- Register 0: value and tag stay 0 permanently. Writes and renames targeting it are ignored.
- `rdy_in` low: no state updates (commit, rename and rollback are all ignored). Reads still reflect current state and bypass.

## Timing
- Reset (`rst_in` high at a rising edge): all values 0, all tags 0. Read outputs are then 0/0 for every index. Reset overrides all other inputs.
- Read latency 0 (combinational). Update latency 1: a rename or commit at edge N is visible to reads after edge N.
- There is no handshake. The RoB asserts `commit_flag` for exactly one cycle per commit. The dispatcher asserts `en_signal_from_dispatcher` for one cycle per rename.
- Priority per register tag: reset > rollback > rename > commit-clear.

## Configuration
- `REG_FILE_TRACE_EN`
  - Defined: add a free-running 32-bit cycle counter, reset to 0. On each effective commit with rd ≠ 0, `$display` the cycle, rd, Q and V.
  - Undefined: no counter and no display. Functional behaviour is identical either way.

## Structure
- Shared package holds:
  - `REG_NUM`, `TAG_W`, `NO_TAG` (= 0).
  - The RoB-id typedef, shared with the RoB, LSB and RS.
- One sub-module, `reg_file_read_port`: index + state + commit bus → V/Q with zero-index and bypass logic. It is instantiated twice (rs1, rs2).

## Test plan
- Reset, then read rs1 = 5, rs2 = 0 → V1 = 0, Q1 = 0, V2 = 0, Q2 = 0.
- Rename x5 → Q = 3, next cycle read x5 → Q1 = 3. Commit (rd = 5, Q = 3, V = 0x1234) with rs1 = 5 in the same cycle → bypass V1 = 0x1234, Q1 = 0. Next cycle, registered value is 0x1234 and tag is 0.
- x7 renamed Q = 2 then Q = 6. Commit (rd = 7, Q = 2, V = 0xAA) → value 0xAA, tag stays 6, and a read of x7 shows Q = 6.
- Same cycle: rename x9 → Q = 4 and commit (rd = 9, Q = 1 matching the old tag, V = 0x55) → value 0x55, tag 4.
- Rename x1 → 2 and x2 → 3, then `rollback_flag` with a same-cycle rename x3 → 5 → all tags 0, x3 tag 0, and previous values intact.
- Rename x0 → 8 and commit (rd = 0, V = 0xFF) → x0 reads V = 0, Q = 0. With `rdy_in` low, a commit to x4 leaves x4 unchanged.
